// File: rtl/dense_sched_pkg.sv
// rtl/dense_sched_pkg.sv - layer geometry, ROM base addresses and FSM states for dense_layer_sched
package dense_sched_pkg;

  localparam int FIXED = 32;
  localparam int W_W   = 8;
  localparam int ACC_W = 48;
  localparam int W_AW  = 12;
  localparam int B_AW  = 6;
  localparam int IDX_W = 7;

  localparam int L0_NIN  = 42;
  localparam int L0_NNEU = 24;
  localparam int L1_NIN  = 24;
  localparam int L1_NNEU = 1;
  localparam int L2_NIN  = 96;
  localparam int L2_NNEU = 22;

  localparam logic [1:0] LYR_L0 = 2'd0;
  localparam logic [1:0] LYR_L1 = 2'd1;
  localparam logic [1:0] LYR_L2 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } st_e;

  function automatic logic [IDX_W-1:0] layer_nin(input logic [1:0] l);
    case (l)
      LYR_L1:  return IDX_W'(L1_NIN);
      LYR_L2:  return IDX_W'(L2_NIN);
      default: return IDX_W'(L0_NIN);
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] layer_nneu(input logic [1:0] l);
    case (l)
      LYR_L1:  return IDX_W'(L1_NNEU);
      LYR_L2:  return IDX_W'(L2_NNEU);
      default: return IDX_W'(L0_NNEU);
    endcase
  endfunction

  function automatic logic [W_AW-1:0] layer_w_base(input logic [1:0] l);
    case (l)
      LYR_L1:  return W_AW'(1008);
      LYR_L2:  return W_AW'(1032);
      default: return W_AW'(0);
    endcase
  endfunction

  function automatic logic [B_AW-1:0] layer_b_base(input logic [1:0] l);
    case (l)
      LYR_L1:  return B_AW'(24);
      LYR_L2:  return B_AW'(25);
      default: return B_AW'(0);
    endcase
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/dense_mac_acc.sv
// rtl/dense_mac_acc.sv - MAC accumulator with 1/256 scale and bias add
// DENSE_SAT_EN: saturate the narrowed result instead of wrapping.
module dense_mac_acc
  import dense_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bias_ld,
  input  logic [W_W-1:0]   w_data,
  input  logic [FIXED-1:0] in_data,
  input  logic [FIXED-1:0] b_data,
  output logic [FIXED-1:0] result
);

  logic signed [ACC_W-1:0]       acc;
  logic signed [W_W+FIXED-1:0]   prod;
  logic signed [ACC_W-1:0]       prod_ext;
  logic        [FIXED-1:0]       bias_q;

  assign prod     = $signed(w_data) * $signed(in_data);
  assign prod_ext = {{(ACC_W-W_W-FIXED){prod[W_W+FIXED-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      bias_q <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc + prod_ext;
      if (bias_ld)
        bias_q <= b_data;
    end
  end

`ifdef DENSE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-FIXED+1){1'b0}}, {(FIXED-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-FIXED+1){1'b1}}, {(FIXED-1){1'b0}}};
  localparam logic [FIXED-1:0] MAX_F = {1'b0, {(FIXED-1){1'b1}}};
  localparam logic [FIXED-1:0] MIN_F = {1'b1, {(FIXED-1){1'b0}}};

  logic signed [ACC_W-1:0] sum;
  assign sum = (acc >>> 8) + {{(ACC_W-FIXED){bias_q[FIXED-1]}}, bias_q};

  always_comb begin
    result = sum[FIXED-1:0];
    if (sum > SAT_MAX)
      result = MAX_F;
    else if (sum < SAT_MIN)
      result = MIN_F;
  end
`else
  // Only the low FIXED bits survive, so the shift reduces to a bit select.
  assign result = acc[FIXED+7:8] + bias_q;
`endif

endmodule

// File: rtl/dense_layer_sched.sv
// rtl/dense_layer_sched.sv - round-robin scheduler for three dense layers over one MAC
module dense_layer_sched
  import dense_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  output logic [2:0]       grant,
  output logic [2:0]       done,
  output logic [W_AW-1:0]  w_addr,
  input  logic [W_W-1:0]   w_data,
  output logic [B_AW-1:0]  b_addr,
  input  logic [FIXED-1:0] b_data,
  output logic [IDX_W-1:0] in_idx,
  input  logic [FIXED-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_layer,
  output logic [IDX_W-1:0] out_idx,
  output logic [FIXED-1:0] out_data
);

  st_e              state_q, state_d;
  logic [2:0]       grant_q;
  logic [1:0]       cur_q, rr_q;
  logic [1:0]       c0, c1, c2, pick;
  logic [IDX_W-1:0] i_q, n_q;
  logic [W_AW-1:0]  w_addr_q;
  logic [B_AW-1:0]  b_addr_q;
  logic [IDX_W-1:0] in_idx_q;
  logic             first_d;
  logic             last_i, last_n;
  logic             acc_clr, acc_en;

  assign c0   = rr_q;
  assign c1   = rr_next(c0);
  assign c2   = rr_next(c1);
  assign pick = req[c0] ? c0 : (req[c1] ? c1 : c2);

  assign last_i = (i_q == layer_nin(cur_q) - 1'b1);
  assign last_n = (n_q == layer_nneu(cur_q) - 1'b1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req != 3'b000) state_d = ST_MAC;
      ST_MAC:   if (last_i) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT:  if (out_ready) state_d = last_n ? ST_DONE : ST_MAC;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Addresses are live only in MAC; elsewhere they replay the last issued value.
  always_comb begin
    w_addr = w_addr_q;
    b_addr = b_addr_q;
    in_idx = in_idx_q;
    if (state_q == ST_MAC) begin
      w_addr = layer_w_base(cur_q)
             + ({{(W_AW-IDX_W){1'b0}}, i_q} * {{(W_AW-IDX_W){1'b0}}, layer_nneu(cur_q)})
             + {{(W_AW-IDX_W){1'b0}}, n_q};
      in_idx = i_q;
      if (i_q == '0)
        b_addr = layer_b_base(cur_q) + {{(B_AW-IDX_W+1){1'b0}}, n_q[IDX_W-2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      cur_q    <= '0;
      rr_q     <= '0;
      i_q      <= '0;
      n_q      <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      in_idx_q <= '0;
      first_d  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr;
      b_addr_q <= b_addr;
      in_idx_q <= in_idx;
      first_d  <= (state_q == ST_MAC) && (i_q == '0);
      case (state_q)
        ST_IDLE: begin
          if (req != 3'b000) begin
            cur_q   <= pick;
            grant_q <= 3'b001 << pick;
            rr_q    <= rr_next(pick);
            n_q     <= '0;
            i_q     <= '0;
          end
        end
        ST_MAC:  i_q <= last_i ? '0 : i_q + 1'b1;
        ST_EMIT: if (out_ready && !last_n) n_q <= n_q + 1'b1;
        ST_DONE: grant_q <= '0;
        default: ;
      endcase
    end
  end

  // Product for input i arrives one cycle after issue, so add on i>0 and in DRAIN.
  assign acc_clr = (state_q == ST_MAC) && (i_q == '0);
  assign acc_en  = ((state_q == ST_MAC) && (i_q != '0)) || (state_q == ST_DRAIN);

  dense_mac_acc u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .bias_ld (first_d),
    .w_data  (w_data),
    .in_data (in_data),
    .b_data  (b_data),
    .result  (out_data)
  );

  assign grant     = grant_q;
  assign done      = (state_q == ST_DONE) ? grant_q : 3'b000;
  assign out_valid = (state_q == ST_EMIT);
  assign out_layer = cur_q;
  assign out_idx   = n_q;

endmodule
